// File: rtl/uart_rx_if.sv
// ============================================================================
// Module      : uart_rx_if
// Description : Peripheral bus bundle between a bus master and uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if;
    logic        enable_i;
    logic [3:0]  wstrb_i;
    logic [31:0] addr_i;
    logic [31:0] wvalue_i;
    logic [31:0] rvalue_o;

    modport master (
        output enable_i,
        output wstrb_i,
        output addr_i,
        output wvalue_i,
        input  rvalue_o
    );

    modport slave (
        input  enable_i,
        input  wstrb_i,
        input  addr_i,
        input  wvalue_i,
        output rvalue_o
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : Memory-mapped 8N1 UART receiver with receive FIFO, DATA and
//               STATUS registers. Optional interrupt output: UART_RX_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int FREQ       = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    input  wire logic   uart_rx_i,
`ifdef UART_RX_IRQ_EN
    output logic        irq_o,
`endif
    uart_rx_if.slave    bus
);

    localparam int c_BIT_CNT = FREQ / BAUD;
    localparam int c_HALF    = c_BIT_CNT / 2;
    localparam int c_CNT_W   = $clog2(c_BIT_CNT + 1);
    localparam int c_AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic                 sync1_q, rx_s_q;
    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [7:0]           mem_d [FIFO_DEPTH];
    logic [c_AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_AW:0]        count_q, count_d;
    logic                 ovr_q, ovr_d, fe_q, fe_d;
    logic [31:0]          rvalue_q, rvalue_d;
    logic                 irq_en;

    logic                 w_push, w_fe_set, w_pop, w_push_ok, w_ovr_set;
    logic                 w_empty, w_full, w_rd, w_wr_status;
    logic [7:0]           w_head;
    logic [31:0]          w_status;
    logic                 w_unused;

    assign w_unused = ^{bus.addr_i[31:4], bus.addr_i[1:0],
                        bus.wvalue_i[31:5], bus.wvalue_i[1:0], bus.wvalue_i[4]};

    // ---------------- receive FSM ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        w_push    = 1'b0;
        w_fe_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == c_CNT_W'(c_HALF - 1)) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A start bit that is high again at mid-bit is a glitch
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == c_CNT_W'(c_BIT_CNT - 1)) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == c_CNT_W'(c_BIT_CNT - 1)) begin
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                    w_push   = rx_s_q;
                    w_fe_set = !rx_s_q;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FIFO and registers ----------------
    assign w_empty     = (count_q == '0);
    assign w_full      = (count_q == (c_AW+1)'(FIFO_DEPTH));
    assign w_head      = w_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign w_rd        = bus.enable_i && (bus.wstrb_i == 4'h0);
    assign w_wr_status = bus.enable_i && bus.wstrb_i[0] && (bus.addr_i[3:2] == 2'd1);
    assign w_pop       = w_rd && (bus.addr_i[3:2] == 2'd0) && !w_empty;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_ovr_set   = w_push && w_full && !w_pop;

    assign w_status = {16'h0000, 8'(count_q), 3'b000, irq_en, fe_q, ovr_q, w_full, !w_empty};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + c_AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_AW'(1);
        end
        count_d = count_q + (c_AW+1)'(w_push_ok) - (c_AW+1)'(w_pop);

        // Set takes priority over a same-cycle write-1-to-clear
        ovr_d = ovr_q;
        fe_d  = fe_q;
        if (w_wr_status && bus.wvalue_i[2]) ovr_d = 1'b0;
        if (w_wr_status && bus.wvalue_i[3]) fe_d  = 1'b0;
        if (w_ovr_set) ovr_d = 1'b1;
        if (w_fe_set)  fe_d  = 1'b1;

        rvalue_d = rvalue_q;
        if (w_rd) begin
            case (bus.addr_i[3:2])
                2'd0:    rvalue_d = {23'h0, !w_empty, w_head};
                2'd1:    rvalue_d = w_status;
                default: rvalue_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
            rvalue_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q   <= uart_rx_i;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            fe_q      <= fe_d;
            rvalue_q  <= rvalue_d;
            mem_q     <= mem_d;
        end
    end

    assign bus.rvalue_o = rvalue_q;

`ifdef UART_RX_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (w_wr_status) irq_en_d = bus.wvalue_i[4];
        irq_d = irq_en_q && (!w_empty || ovr_q || fe_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en = irq_en_q;
    assign irq_o  = irq_q;
`else
    assign irq_en = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Memory-mapped UART receiver, 8N1 format, companion to the existing UART transmitter on the same peripheral bus. It synchronises the serial input and detects a start bit. It then samples each bit at mid-bit and pushes received bytes into a small receive FIFO. Software reads bytes and status through two word registers; the read data path has one-cycle latency.

Parameters:
FREQ, 27000000, clock frequency in Hz.
BAUD, 115200, line rate. BIT_CNT = FREQ/BAUD; HALF = BIT_CNT/2. BIT_CNT must be >= 4.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2, <= 128.

Ports:
clk_i  in  1  single clock; all logic on its rising edge.
rst_i  in  1  asynchronous, active-high reset.
uart_rx_i  in  1  serial line, idle high, asynchronous to clk_i.
enable_i  in  1  bus access strobe.
wstrb_i  in  4  byte write strobes; all-zero means read.
addr_i  in  32  byte address; only [3:2] decoded.
wvalue_i  in  32  write data.
rvalue_o  out  32  registered read data.

Behaviour:
- Reset values:
  - Both synchroniser flops = 1.
  - FSM in IDLE; counters = 0.
  - FIFO empty; overrun and frame-error flags = 0; irq enable = 0.
  - rvalue_o = 0.
- Reset mid-frame discards the partial byte and all FIFO contents.
- Input: 2-flop synchroniser. The FSM sees only the second flop output, rx_s.
- FSM states:
  - IDLE: when rx_s == 0, go to START with cnt = 0.
  - START: when cnt == HALF-1, re-check rx_s.
    - rx_s == 0: go to DATA with cnt = 0, bit index = 0.
    - rx_s == 1: treat as a glitch; return to IDLE. No flags set.
  - DATA: when cnt == BIT_CNT-1, shift rx_s into the shift register, LSB first (shift right, new bit enters [7]). Set cnt = 0 and increment the bit index. After the 8th bit, go to STOP.
  - STOP: when cnt == BIT_CNT-1, sample rx_s, then go to IDLE.
    - rx_s == 1: push the byte into the FIFO.
    - rx_s == 0: set frame-error; drop the byte.
- In all states other than IDLE, cnt increments by 1 each cycle when not at its terminal value.
- FIFO push when full:
  - If a pop occurs in the same cycle, the push is accepted with no overrun.
  - Otherwise set overrun and drop the new byte; FIFO contents are unchanged.
- Simultaneous push and pop: both take effect; count is unchanged.
- Register map (addr_i[3:2]):
  - 0, DATA, read: [8] = FIFO non-empty, [7:0] = head byte (0 when empty), other bits 0. A read pops the FIFO when it is non-empty. Reading an empty FIFO has no effect.
  - 1, STATUS, read: [0] non-empty, [1] full, [2] overrun (sticky), [3] frame-error (sticky), [4] irq enable, [15:8] FIFO count (zero-extended), other bits 0.
  - 1, STATUS, write with wstrb_i[0]: [2] and [3] are write-1-to-clear; [4] loads irq enable.
  - 2 and 3: read 0; writes ignored. Writes to DATA are ignored.
- Read access = enable_i & (wstrb_i == 0).
  - rvalue_o is loaded on the clock edge of the access and is valid in the following cycle.
  - rvalue_o holds its value when there is no read access.
- A sticky flag set and a W1C clear in the same cycle: set wins.

Optional Feature:
Macro UART_RX_IRQ_EN.
- Defined: adds output port irq_o (1 bit), registered, reset 0. irq_o = irq enable & (FIFO non-empty | overrun | frame-error), updated each cycle.
- Undefined: irq_o port is absent; STATUS[4] reads 0; writes to STATUS[4] are ignored.

Test Plan:
All scenarios use FREQ=1600000, BAUD=100000, so BIT_CNT=16 and HALF=8.
1. Drive 0xA5 as an 8N1 frame at 16 clocks/bit, then read DATA -> rvalue_o = 0x000001A5 the cycle after the access. A following STATUS read -> [0]=0, count 0.
2. Pulse uart_rx_i low for 4 clocks, then hold high -> no push; STATUS = 0; FSM back in IDLE.
3. Send 0x3C with the stop bit driven 0 -> FIFO empty, STATUS[3]=1. Write STATUS with 0x8 -> STATUS[3]=0.
4. Send 5 bytes 0x01..0x05 with no reads -> STATUS[1]=1, [2]=1, count 4. Four DATA reads return 0x101, 0x102, 0x103, 0x104; a fifth read returns 0x000.
5. Assert rst_i during bit 3 of a frame, release, then send 0x7E -> only 0x7E is received; flags are 0.
6. With UART_RX_IRQ_EN defined: write STATUS with 0x10, then receive 0x55 -> irq_o rises within 2 cycles of the stop-bit sample. Reading DATA clears irq_o.
